// File: rtl/binop_fifo_pkg.sv
// binop_fifo_pkg: register map addresses and operator modes shared by the binop FIFO accelerator
package binop_fifo_pkg;
  localparam logic [2:0] RD_A_NF   = 3'd0;
  localparam logic [2:0] RD_B_NF   = 3'd1;
  localparam logic [2:0] RD_Y_NE   = 3'd2;
  localparam logic [2:0] RD_Y_DATA = 3'd3;
  localparam logic [2:0] RD_A_CNT  = 3'd4;
  localparam logic [2:0] RD_B_CNT  = 3'd5;
  localparam logic [2:0] RD_Y_CNT  = 3'd6;
  localparam logic [2:0] RD_MODE   = 3'd7;
  localparam logic [2:0] WR_A      = 3'd4;
  localparam logic [2:0] WR_B      = 3'd5;
  localparam logic [2:0] WR_MODE   = 3'd6;
  localparam logic [2:0] WR_FLUSH  = 3'd7;
  typedef enum logic [1:0] {OP_XOR, OP_AND, OP_OR, OP_XNOR} op_e;
endpackage

// File: rtl/binop_fifo_accel_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO (clk, rst, push/pop/flush, din -> dout, not_full, not_empty, count)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             not_full,
  output logic             not_empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign not_full  = count < CW'(DEPTH);
  assign not_empty = count != '0;
  assign do_push   = push && not_full;
  assign do_pop    = pop && not_empty;
  assign dout      = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/binop_fifo_accel.sv
// binop_fifo_accel: A/B operand FIFOs -> bitwise op -> Y FIFO over a 3-bit-address read/write register bus (CLK, RST, read_*, write_*)
module binop_fifo_accel
  import binop_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy,
  input  logic [2:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] a_head, b_head, y_head, y_in;
  logic a_nf, b_nf, y_nf, a_ne, b_ne, y_ne;
  logic [CW-1:0] a_cnt, b_cnt, y_cnt;
  logic wr_go, push_a, push_b, wr_mode, flush, pop_y, compute;
  op_e mode;
  assign write_rdy = write_address == WR_A ? a_nf : write_address == WR_B ? b_nf : write_address[2];
  assign read_rdy  = read_address == RD_Y_DATA ? y_ne : 1'b1;
  assign wr_go     = write_en && write_rdy;
  assign push_a    = wr_go && write_address == WR_A;
  assign push_b    = wr_go && write_address == WR_B;
  assign wr_mode   = wr_go && write_address == WR_MODE;
  assign flush     = wr_go && write_address == WR_FLUSH && write_data[0];
  assign pop_y     = read_en && read_rdy && read_address == RD_Y_DATA;
  // Y must have a free slot before the edge; a same-cycle Y pop does not make room.
  assign compute   = a_ne && b_ne && y_nf;
  always_comb begin
    y_in = mode == OP_XOR ? a_head ^ b_head :
           mode == OP_AND ? a_head & b_head :
           mode == OP_OR  ? a_head | b_head : ~(a_head ^ b_head);
  end
  always_comb begin
    read_data = '0;
    case (read_address)
      RD_A_NF:   read_data = WIDTH'(a_nf);
      RD_B_NF:   read_data = WIDTH'(b_nf);
      RD_Y_NE:   read_data = WIDTH'(y_ne);
      RD_Y_DATA: read_data = y_ne ? y_head : '0;
      RD_A_CNT:  read_data = WIDTH'(a_cnt);
      RD_B_CNT:  read_data = WIDTH'(b_cnt);
      RD_Y_CNT:  read_data = WIDTH'(y_cnt);
      RD_MODE:   read_data = WIDTH'(mode);
      default:   read_data = '0;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) mode <= OP_XOR;
    else if (wr_mode) mode <= op_e'(write_data[1:0]);
  end
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_a (
    .clk(CLK), .rst(RST), .push(push_a), .pop(compute), .flush(flush), .din(write_data),
    .dout(a_head), .not_full(a_nf), .not_empty(a_ne), .count(a_cnt)
  );
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_b (
    .clk(CLK), .rst(RST), .push(push_b), .pop(compute), .flush(flush), .din(write_data),
    .dout(b_head), .not_full(b_nf), .not_empty(b_ne), .count(b_cnt)
  );
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_y (
    .clk(CLK), .rst(RST), .push(compute), .pop(pop_y), .flush(flush), .din(y_in),
    .dout(y_head), .not_full(y_nf), .not_empty(y_ne), .count(y_cnt)
  );
endmodule
